// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller
//
// Linear frequency-sweep sequencer for the DDS phase accumulator.
// It steps a tuning word from a start word to a stop word. Each word is
// held for a programmable dwell. The sweep can run once or repeat.
//
// Ports
//   clk        system clock; all logic runs on its rising edge
//   resetn     synchronous, active-low reset
//   start      start request; only looked at in IDLE
//   abort      stops the sweep at once; wins over start
//   mode       0 = single sweep, 1 = continuous
//   ftw_start  first tuning word
//   ftw_stop   last tuning word
//   ftw_step   step magnitude (unsigned)
//   dwell      cycles each word is held; 0 behaves as 1
//   ftw_out    registered tuning word to the DDS
//   ftw_load   one-cycle strobe, high when ftw_out takes a new value
//   busy       high while a sweep is in progress
//   done       one-cycle pulse when a single sweep completes
//   pwm_en     PWM gate; always equal to busy
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no sweep running; ftw_out holds its last value
// DWELL | holding the current word until the dwell count reaches 0
module dds_sweep_controller #(
    parameter int FTW_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic               mode,
    input  logic [FTW_W-1:0]   ftw_start,
    input  logic [FTW_W-1:0]   ftw_stop,
    input  logic [FTW_W-1:0]   ftw_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FTW_W-1:0]   ftw_out,
    output logic               ftw_load,
    output logic               busy,
    output logic               done,
    output logic               pwm_en
);

    typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [DWELL_W-1:0]   count_q, count_d;
    logic [FTW_W-1:0]     sh_start_q, sh_start_d;
    logic [FTW_W-1:0]     sh_stop_q, sh_stop_d;
    logic [FTW_W-1:0]     sh_step_q, sh_step_d;
    logic [DWELL_W-1:0]   sh_dwell_q, sh_dwell_d;
    logic                 sh_mode_q, sh_mode_d;
    logic                 dir_up_q, dir_up_d;
    logic [FTW_W-1:0]     ftw_d;
    logic                 load_d, done_d;

    logic [DWELL_W-1:0]   dwell_eff;
    logic [FTW_W:0]       sum_ext, diff_ext;
    logic [FTW_W-1:0]     next_word;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    // The extra MSB catches carry-out on the way up and borrow on the way
    // down. Either one means we passed the stop word, so clamp to it.
    assign sum_ext  = {1'b0, ftw_out} + {1'b0, sh_step_q};
    assign diff_ext = {1'b0, ftw_out} - {1'b0, sh_step_q};

    always_comb begin
        next_word = sh_stop_q;
        if (sh_step_q != '0) begin
            if (dir_up_q) begin
                if (!sum_ext[FTW_W] && (sum_ext[FTW_W-1:0] <= sh_stop_q))
                    next_word = sum_ext[FTW_W-1:0];
            end else begin
                if (!diff_ext[FTW_W] && (diff_ext[FTW_W-1:0] >= sh_stop_q))
                    next_word = diff_ext[FTW_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sh_start_d = sh_start_q;
        sh_stop_d  = sh_stop_q;
        sh_step_d  = sh_step_q;
        sh_dwell_d = sh_dwell_q;
        sh_mode_d  = sh_mode_q;
        dir_up_d   = dir_up_q;
        ftw_d      = ftw_out;
        load_d     = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    sh_start_d = ftw_start;
                    sh_stop_d  = ftw_stop;
                    sh_step_d  = ftw_step;
                    sh_dwell_d = dwell_eff;
                    sh_mode_d  = mode;
                    dir_up_d   = (ftw_stop >= ftw_start);
                    ftw_d      = ftw_start;
                    load_d     = 1'b1;
                    count_d    = dwell_eff - DWELL_W'(1);
                    state_d    = DWELL;
                end
            end
            DWELL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (count_q != '0) begin
                    count_d = count_q - DWELL_W'(1);
                end else if (ftw_out != sh_stop_q) begin
                    ftw_d   = next_word;
                    load_d  = 1'b1;
                    count_d = sh_dwell_q - DWELL_W'(1);
                end else if (sh_mode_q) begin
                    ftw_d   = sh_start_q;
                    load_d  = 1'b1;
                    count_d = sh_dwell_q - DWELL_W'(1);
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            count_q    <= '0;
            sh_start_q <= '0;
            sh_stop_q  <= '0;
            sh_step_q  <= '0;
            sh_dwell_q <= '0;
            sh_mode_q  <= 1'b0;
            dir_up_q   <= 1'b0;
            ftw_out    <= '0;
            ftw_load   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sh_start_q <= sh_start_d;
            sh_stop_q  <= sh_stop_d;
            sh_step_q  <= sh_step_d;
            sh_dwell_q <= sh_dwell_d;
            sh_mode_q  <= sh_mode_d;
            dir_up_q   <= dir_up_d;
            ftw_out    <= ftw_d;
            ftw_load   <= load_d;
            done       <= done_d;
            busy       <= (state_d == DWELL);
        end
    end

    assign pwm_en = busy;

endmodule
